// File: rtl/gfsk_iq_discriminator.sv
`timescale 1ns/1ps
// Purpose: GFSK hard-decision demodulator; centers I/Q, cross-product discriminator, per-symbol integrate-and-dump.
// Latency: last sample of a symbol captured at edge E -> out_valid/out_bit/out_metric update at edge E+2.
// Backpressure: single-entry output buffer; a symbol completing while the buffer is full and not drained is dropped, sets sticky overflow.
//
// Ports:
//   clock, reset            40 MHz sample clock, synchronous active-high reset
//   enable                  0 = idle/flush the datapath, 1 = run
//   in_valid, i_in, q_in    unsigned ADC I/Q sample and its qualifier
//   out_valid, out_ready    ready/valid symbol handshake
//   out_bit, out_metric     hard decision (1 = positive deviation) and signed integrated metric
//   overflow                sticky: a symbol was dropped because the consumer stalled
module gfsk_iq_discriminator #(
   parameter int IQ_WIDTH        = 5,
   parameter int MID             = 16,
   parameter int SAMPLES_PER_SYM = 40,
   parameter int ACC_WIDTH       = 16,
   parameter int THRESH          = 0
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        enable,
   input  logic                        in_valid,
   input  logic [IQ_WIDTH-1:0]         i_in,
   input  logic [IQ_WIDTH-1:0]         q_in,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic                        out_bit,
   output logic signed [ACC_WIDTH-1:0] out_metric,
   output logic                        overflow
);

   localparam int CW    = IQ_WIDTH + 1;        // centered sample width
   localparam int DW    = 2 * CW - 1;          // exact discriminator width
   localparam int CNT_W = $clog2(SAMPLES_PER_SYM + 1);

   localparam logic signed [ACC_WIDTH-1:0] THR     = ACC_WIDTH'(THRESH);
   localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, PRIME, ACCUM} state_t;

   state_t state_q, state_d;

   // stage 1: history and the registered (prev, cur) pair
   logic signed [CW-1:0] hist_i, hist_q;
   logic signed [CW-1:0] s1_pi, s1_pq, s1_ci, s1_cq;
   logic                 s1_vld, s1_last;
   logic [CNT_W-1:0]     count;

   // stage 2: discriminator product
   logic signed [DW-1:0] s2_d;
   logic                 s2_vld, s2_last;

   // stage 3: accumulator
   logic signed [ACC_WIDTH-1:0] acc;

   logic signed [CW-1:0]        ic_new, qc_new;
   logic signed [2*CW-1:0]      prod_a, prod_b;
   logic signed [DW-1:0]        d_cmb;
   logic signed [ACC_WIDTH:0]   sum_ext;
   logic signed [ACC_WIDTH-1:0] acc_sat;
   logic                        sample_take;
   logic                        cnt_last;
   logic                        sym_done;

   assign ic_new = $signed({1'b0, i_in}) - $signed(CW'(MID));
   assign qc_new = $signed({1'b0, q_in}) - $signed(CW'(MID));

   // d = Qprev*Icur - Iprev*Qcur; magnitude never exceeds DW bits, so the truncation is exact
   assign prod_a = s1_pq * s1_ci;
   assign prod_b = s1_pi * s1_cq;
   assign d_cmb  = DW'(prod_a - prod_b);

   // one guard bit detects overflow of the signed add; clamp to the rail on the side of the true sum
   assign sum_ext = $signed({acc[ACC_WIDTH-1], acc})
                  + $signed({{(ACC_WIDTH+1-DW){s2_d[DW-1]}}, s2_d});
   always_comb begin
      acc_sat = sum_ext[ACC_WIDTH-1:0];
      if (sum_ext[ACC_WIDTH] != sum_ext[ACC_WIDTH-1])
         acc_sat = sum_ext[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
   end

   // samples arriving while still in IDLE are ignored; PRIME takes the first one as history only
   assign sample_take = enable && in_valid && (state_q != IDLE);
   assign cnt_last    = (count == CNT_W'(SAMPLES_PER_SYM - 1));
   assign sym_done    = enable && s2_vld && s2_last;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (enable)   state_d = PRIME;
         PRIME:   if (in_valid) state_d = ACCUM;
         ACCUM:                 state_d = ACCUM;
         default:               state_d = IDLE;
      endcase
      if (!enable) state_d = IDLE;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         hist_i     <= '0;
         hist_q     <= '0;
         s1_pi      <= '0;
         s1_pq      <= '0;
         s1_ci      <= '0;
         s1_cq      <= '0;
         s1_vld     <= 1'b0;
         s1_last    <= 1'b0;
         count      <= '0;
         s2_d       <= '0;
         s2_vld     <= 1'b0;
         s2_last    <= 1'b0;
         acc        <= '0;
         out_valid  <= 1'b0;
         out_bit    <= 1'b0;
         out_metric <= '0;
         overflow   <= 1'b0;
      end else begin
         state_q <= state_d;

         if (!enable) begin
            // flush: any partial symbol in flight is discarded
            hist_i  <= '0;
            hist_q  <= '0;
            s1_vld  <= 1'b0;
            s1_last <= 1'b0;
            count   <= '0;
            s2_vld  <= 1'b0;
            s2_last <= 1'b0;
            acc     <= '0;
         end else begin
            s1_vld  <= 1'b0;
            s1_last <= 1'b0;
            if (sample_take) begin
               hist_i <= ic_new;
               hist_q <= qc_new;
               s1_pi  <= hist_i;
               s1_pq  <= hist_q;
               s1_ci  <= ic_new;
               s1_cq  <= qc_new;
               if (state_q == ACCUM) begin
                  s1_vld  <= 1'b1;
                  s1_last <= cnt_last;
                  count   <= cnt_last ? '0 : count + 1'b1;
               end
            end

            s2_vld  <= s1_vld;
            s2_last <= s1_last;
            if (s1_vld) s2_d <= d_cmb;

            if (s2_vld) acc <= s2_last ? '0 : acc_sat;
         end

         if (sym_done) begin
            if (!out_valid || out_ready) begin
               out_valid  <= 1'b1;
               out_metric <= acc_sat;
               out_bit    <= (acc_sat > THR);
            end else begin
               overflow <= 1'b1;
            end
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_gfsk_iq_discriminator.sv
`timescale 1ns/1ps
module tb_gfsk_iq_discriminator;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic        in_valid = 1'b0;
   logic [4:0]  i_in = 5'd16;
   logic [4:0]  q_in = 5'd16;
   logic        out_ready = 1'b0;

   logic               out_valid, out_bit, overflow;
   logic signed [15:0] out_metric;
   logic               v12, b12, ovf12;
   logic signed [11:0] m12;

   int n_checks = 0;
   int n_fail   = 0;
   int phase    = 0;

   always #5 clock = ~clock;

   gfsk_iq_discriminator dut (
      .clock(clock), .reset(reset), .enable(enable), .in_valid(in_valid),
      .i_in(i_in), .q_in(q_in), .out_valid(out_valid), .out_ready(out_ready),
      .out_bit(out_bit), .out_metric(out_metric), .overflow(overflow)
   );

   gfsk_iq_discriminator #(.ACC_WIDTH(12)) dut12 (
      .clock(clock), .reset(reset), .enable(enable), .in_valid(in_valid),
      .i_in(i_in), .q_in(q_in), .out_valid(v12), .out_ready(out_ready),
      .out_bit(b12), .out_metric(m12), .overflow(ovf12)
   );

   // dir 0: constant mid-scale; +1/-1: step around (0,10),(10,0),(0,-10),(-10,0) giving d=+100/-100.
   // bub>0 inserts a bubble cycle before every sample with k%bub==1.
   task automatic send(input int n, input int dir, input int bub);
      for (int k = 0; k < n; k++) begin
         if (bub != 0 && (k % bub) == 1) begin
            @(negedge clock);
            in_valid = 1'b0;
         end
         @(negedge clock);
         in_valid = 1'b1;
         if (dir == 0) begin
            i_in = 5'd16; q_in = 5'd16;
         end else begin
            phase = (phase + dir + 4) % 4;
            case (phase)
               0: begin i_in = 5'd16; q_in = 5'd26; end
               1: begin i_in = 5'd26; q_in = 5'd16; end
               2: begin i_in = 5'd16; q_in = 5'd6;  end
               default: begin i_in = 5'd6; q_in = 5'd16; end
            endcase
         end
      end
   endtask

   // one idle cycle (drains any pending output), then enable rises so the next sample primes
   task automatic restart();
      @(negedge clock);
      enable = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clock);
      enable = 1'b1; out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; enable = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      repeat (3) @(negedge clock);
      if (out_valid !== 1'b0) begin $display("FAIL rst_valid: got %b want 0", out_valid); n_fail++; end
      n_checks++;
      if (out_bit !== 1'b0) begin $display("FAIL rst_bit: got %b want 0", out_bit); n_fail++; end
      n_checks++;
      if (out_metric !== 16'sd0) begin $display("FAIL rst_metric: got %0d want 0", out_metric); n_fail++; end
      n_checks++;
      if (overflow !== 1'b0) begin $display("FAIL rst_overflow: got %b want 0", overflow); n_fail++; end
      n_checks++;
      reset = 1'b0;
   endtask

   task automatic test_constant();
      restart();
      send(41, 0, 0);
      @(negedge clock); in_valid = 1'b0;
      @(negedge clock);
      if (out_valid !== 1'b0) begin $display("FAIL const_early: got %b want 0", out_valid); n_fail++; end
      n_checks++;
      @(negedge clock);
      if (out_valid !== 1'b1) begin $display("FAIL const_valid: got %b want 1", out_valid); n_fail++; end
      n_checks++;
      if (out_metric !== 16'sd0 || out_bit !== 1'b0) begin
         $display("FAIL const_value: got metric %0d bit %b want 0 0", out_metric, out_bit); n_fail++;
      end
      n_checks++;
      out_ready = 1'b1;
      @(negedge clock); out_ready = 1'b0;
      if (out_valid !== 1'b0) begin $display("FAIL const_drain: got %b want 0", out_valid); n_fail++; end
      n_checks++;
   endtask

   task automatic test_forward();
      restart();
      out_ready = 1'b1;
      send(41, 1, 0);
      @(negedge clock); in_valid = 1'b0;
      @(negedge clock);
      if (out_valid !== 1'b0) begin $display("FAIL fwd_early: got %b want 0", out_valid); n_fail++; end
      n_checks++;
      @(negedge clock);
      if (out_valid !== 1'b1 || out_metric !== 16'sd4000 || out_bit !== 1'b1) begin
         $display("FAIL fwd_sym1: got v%b m%0d b%b want v1 m4000 b1", out_valid, out_metric, out_bit); n_fail++;
      end
      n_checks++;
      if (m12 !== 12'sd2047 || b12 !== 1'b1) begin
         $display("FAIL fwd_sat12: got m%0d b%b want m2047 b1", m12, b12); n_fail++;
      end
      n_checks++;
      @(negedge clock);
      if (out_valid !== 1'b0) begin $display("FAIL fwd_consumed: got %b want 0", out_valid); n_fail++; end
      n_checks++;
      send(40, 1, 0);
      @(negedge clock); in_valid = 1'b0;
      @(negedge clock);
      if (out_valid !== 1'b0) begin $display("FAIL fwd2_early: got %b want 0", out_valid); n_fail++; end
      n_checks++;
      @(negedge clock);
      if (out_valid !== 1'b1 || out_metric !== 16'sd4000) begin
         $display("FAIL fwd_sym2: got v%b m%0d want v1 m4000", out_valid, out_metric); n_fail++;
      end
      n_checks++;
      out_ready = 1'b0;
   endtask

   task automatic test_reverse(input int bub);
      restart();
      send(41, -1, bub);
      @(negedge clock); in_valid = 1'b0;
      @(negedge clock);
      if (out_valid !== 1'b0) begin $display("FAIL rev_early(bub=%0d): got %b want 0", bub, out_valid); n_fail++; end
      n_checks++;
      @(negedge clock);
      if (out_valid !== 1'b1 || out_metric !== -16'sd4000 || out_bit !== 1'b0) begin
         $display("FAIL rev_sym(bub=%0d): got v%b m%0d b%b want v1 m-4000 b0", bub, out_valid, out_metric, out_bit);
         n_fail++;
      end
      n_checks++;
      if (m12 !== -12'sd2048 || b12 !== 1'b0) begin
         $display("FAIL rev_sat12(bub=%0d): got m%0d b%b want m-2048 b0", bub, m12, b12); n_fail++;
      end
      n_checks++;
   endtask

   task automatic test_overflow();
      restart();
      send(41, 1, 0);
      @(negedge clock); in_valid = 1'b0;
      repeat (2) @(negedge clock);
      if (out_valid !== 1'b1 || overflow !== 1'b0) begin
         $display("FAIL ovf_first: got v%b ovf%b want v1 ovf0", out_valid, overflow); n_fail++;
      end
      n_checks++;
      send(40, -1, 0);
      @(negedge clock); in_valid = 1'b0;
      repeat (3) @(negedge clock);
      if (out_valid !== 1'b1 || out_metric !== 16'sd4000 || out_bit !== 1'b1) begin
         $display("FAIL ovf_held: got v%b m%0d b%b want v1 m4000 b1", out_valid, out_metric, out_bit); n_fail++;
      end
      n_checks++;
      if (overflow !== 1'b1 || ovf12 !== 1'b1) begin
         $display("FAIL ovf_flag: got %b/%b want 1/1", overflow, ovf12); n_fail++;
      end
      n_checks++;
      out_ready = 1'b1;
      @(negedge clock); out_ready = 1'b0;
      if (out_valid !== 1'b0 || out_metric !== 16'sd4000) begin
         $display("FAIL ovf_drain: got v%b m%0d want v0 m4000", out_valid, out_metric); n_fail++;
      end
      n_checks++;
   endtask

   task automatic test_enable_flush();
      restart();
      send(21, 1, 0);
      @(negedge clock); enable = 1'b0; in_valid = 1'b0;
      @(negedge clock); enable = 1'b1;
      if (out_valid !== 1'b0) begin $display("FAIL en_partial: got %b want 0", out_valid); n_fail++; end
      n_checks++;
      send(41, 1, 0);
      @(negedge clock); in_valid = 1'b0;
      @(negedge clock);
      if (out_valid !== 1'b0) begin $display("FAIL en_early: got %b want 0", out_valid); n_fail++; end
      n_checks++;
      @(negedge clock);
      if (out_valid !== 1'b1 || out_metric !== 16'sd4000) begin
         $display("FAIL en_sym: got v%b m%0d want v1 m4000", out_valid, out_metric); n_fail++;
      end
      n_checks++;
   endtask

   task automatic test_reset_midsymbol();
      if (overflow !== 1'b1) begin $display("FAIL mid_sticky: got %b want 1", overflow); n_fail++; end
      n_checks++;
      send(21, 1, 0);
      @(negedge clock); reset = 1'b1; in_valid = 1'b0;
      @(negedge clock); reset = 1'b0;
      if (out_valid !== 1'b0 || out_bit !== 1'b0 || out_metric !== 16'sd0 || overflow !== 1'b0) begin
         $display("FAIL mid_reset: got v%b b%b m%0d ovf%b want 0 0 0 0", out_valid, out_bit, out_metric, overflow);
         n_fail++;
      end
      n_checks++;
      send(41, 1, 0);
      @(negedge clock); in_valid = 1'b0;
      @(negedge clock);
      if (out_valid !== 1'b0) begin $display("FAIL mid_early: got %b want 0", out_valid); n_fail++; end
      n_checks++;
      @(negedge clock);
      if (out_valid !== 1'b1 || out_metric !== 16'sd4000 || out_bit !== 1'b1) begin
         $display("FAIL mid_sym: got v%b m%0d b%b want v1 m4000 b1", out_valid, out_metric, out_bit); n_fail++;
      end
      n_checks++;
   endtask

   initial begin
      test_reset();
      test_constant();
      test_forward();
      test_reverse(0);
      test_reverse(3);
      test_overflow();
      test_enable_flush();
      test_reset_midsymbol();
      repeat (2) @(negedge clock);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
